// File: rtl/billiard_pkg.sv
// Shared types and default timing constants for the billiard strike path.
package billiard_pkg;

  localparam int unsigned DEF_ANGLE_W         = 5;
  localparam int unsigned DEF_POWER_W         = 4;
  localparam int unsigned DEF_MAX_POWER       = 15;
  localparam int unsigned DEF_CHARGE_FRAMES   = 4;
  localparam int unsigned DEF_ANGLE_FRAMES    = 3;
  localparam int unsigned DEF_COOLDOWN_FRAMES = 30;

  typedef enum logic [2:0] {
    S_WAIT,
    S_AIM,
    S_CHARGE,
    S_FIRE,
    S_COOLDOWN
  } strike_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/strike_controller_if.sv
// Key/frame inputs and shot outputs of the strike controller, grouped as one bundle.
interface strike_controller_if #(
  parameter int unsigned ANGLE_W = billiard_pkg::DEF_ANGLE_W,
  parameter int unsigned POWER_W = billiard_pkg::DEF_POWER_W
);

  logic               startOfFrame;
  logic               game_state;
  logic               no_moving_flag;
  logic               charge_key;
  logic               left_key;
  logic               right_key;
  logic               strike;
  logic [ANGLE_W-1:0] strike_angle;
  logic [POWER_W-1:0] strike_power;
  logic               charging;
  logic               aim_visible;

  modport master (
    output startOfFrame, game_state, no_moving_flag, charge_key, left_key, right_key,
    input  strike, strike_angle, strike_power, charging, aim_visible
  );

  modport slave (
    input  startOfFrame, game_state, no_moving_flag, charge_key, left_key, right_key,
    output strike, strike_angle, strike_power, charging, aim_visible
  );

endinterface

// File: rtl/frame_tick_div.sv
// Frame-paced divider: counts startOfFrame pulses and flags every period-th one.
module frame_tick_div #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         tick_c
);

  logic [W-1:0] cnt;

  // Tick is combinational so the consumer acts on the same edge the count wraps.
  assign tick_c = frame & ~clear & (cnt == (period - W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (frame) begin
      cnt <= tick_c ? '0 : (cnt + W'(1));
    end
  end

endmodule

// File: rtl/strike_controller.sv
// Cue aim/charge/fire controller feeding the game FSM and white-ball loader.
// Build option STRIKE_OSCILLATE_EN: power ping-pongs 0..MAX_POWER..0 while charging.
module strike_controller
  import billiard_pkg::*;
#(
  parameter int unsigned ANGLE_W         = DEF_ANGLE_W,
  parameter int unsigned POWER_W         = DEF_POWER_W,
  parameter int unsigned MAX_POWER       = DEF_MAX_POWER,
  parameter int unsigned CHARGE_FRAMES   = DEF_CHARGE_FRAMES,
  parameter int unsigned ANGLE_FRAMES    = DEF_ANGLE_FRAMES,
  parameter int unsigned COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  strike_controller_if.slave bus
);

  localparam int unsigned AC_W = $clog2(ANGLE_FRAMES + 1);
  localparam int unsigned FC_W = $clog2(max_u(COOLDOWN_FRAMES, CHARGE_FRAMES) + 1);

  strike_state_t      state, state_n;
  logic [ANGLE_W-1:0] angle, angle_n;
  logic [POWER_W-1:0] power, power_n;
  logic               strike_q, charging_q, aim_q;

  logic               one_key_c;
  logic               angle_clear_c, angle_tick_c;
  logic               frame_clear_c, frame_tick_c;
  logic [FC_W-1:0]    frame_period_c;

`ifdef STRIKE_OSCILLATE_EN
  logic               power_down, power_down_n;
`endif

  assign one_key_c      = bus.left_key ^ bus.right_key;
  assign angle_clear_c  = (state != S_AIM) | ~one_key_c;
  // Charge and cooldown never overlap, so they share one divider.
  assign frame_clear_c  = (state != S_CHARGE) & (state != S_COOLDOWN);
  assign frame_period_c = (state == S_COOLDOWN) ? FC_W'(COOLDOWN_FRAMES) : FC_W'(CHARGE_FRAMES);

  frame_tick_div #(.W(AC_W)) u_angle_div (
    .clk    (clk),
    .rst_n  (resetN),
    .frame  (bus.startOfFrame),
    .clear  (angle_clear_c),
    .period (AC_W'(ANGLE_FRAMES)),
    .tick_c (angle_tick_c)
  );

  frame_tick_div #(.W(FC_W)) u_frame_div (
    .clk    (clk),
    .rst_n  (resetN),
    .frame  (bus.startOfFrame),
    .clear  (frame_clear_c),
    .period (frame_period_c),
    .tick_c (frame_tick_c)
  );

  always_comb begin
    state_n = state;
    angle_n = angle;
    power_n = power;
`ifdef STRIKE_OSCILLATE_EN
    power_down_n = power_down;
`endif

    case (state)
      // Holding charge on entry keeps us here, so a held key never auto-fires.
      S_WAIT: begin
        if (bus.game_state && bus.no_moving_flag && !bus.charge_key) begin
          state_n = S_AIM;
        end
      end

      S_AIM: begin
        if (angle_tick_c) begin
          angle_n = bus.left_key ? (angle - ANGLE_W'(1)) : (angle + ANGLE_W'(1));
        end
        if (bus.charge_key) begin
          state_n = S_CHARGE;
          power_n = '0;
`ifdef STRIKE_OSCILLATE_EN
          power_down_n = 1'b0;
`endif
        end
      end

      S_CHARGE: begin
        if (!bus.charge_key) begin
          state_n = (power != '0) ? S_FIRE : S_AIM;
        end else if (frame_tick_c) begin
`ifdef STRIKE_OSCILLATE_EN
          if (power_down) begin
            power_n = power - POWER_W'(1);
            if (power == POWER_W'(1)) power_down_n = 1'b0;
          end else begin
            power_n = power + POWER_W'(1);
            if (power == POWER_W'(MAX_POWER - 1)) power_down_n = 1'b1;
          end
`else
          if (power != POWER_W'(MAX_POWER)) begin
            power_n = power + POWER_W'(1);
          end
`endif
        end
      end

      S_FIRE: begin
        state_n = S_COOLDOWN;
        power_n = '0;
      end

      S_COOLDOWN: begin
        if (!bus.no_moving_flag || frame_tick_c) begin
          state_n = S_WAIT;
        end
      end

      default: begin
        state_n = S_WAIT;
        power_n = '0;
      end
    endcase

    // Leaving play aborts everything but an in-flight strike pulse; aim is kept.
    if (!bus.game_state && (state != S_FIRE)) begin
      state_n = S_WAIT;
      angle_n = angle;
      power_n = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= S_WAIT;
      angle      <= '0;
      power      <= '0;
      strike_q   <= 1'b0;
      charging_q <= 1'b0;
      aim_q      <= 1'b0;
    end else begin
      state      <= state_n;
      angle      <= angle_n;
      power      <= power_n;
      strike_q   <= (state_n == S_FIRE);
      charging_q <= (state_n == S_CHARGE);
      aim_q      <= (state_n == S_AIM) || (state_n == S_CHARGE);
    end
  end

`ifdef STRIKE_OSCILLATE_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      power_down <= 1'b0;
    end else begin
      power_down <= power_down_n;
    end
  end
`endif

  assign bus.strike       = strike_q;
  assign bus.strike_angle = angle;
  assign bus.strike_power = power;
  assign bus.charging     = charging_q;
  assign bus.aim_visible  = aim_q;

endmodule

// File: tb/tb_strike_controller.sv
// Bench for strike_controller: aim vector table plus charge/fire/cooldown/reset sequences.
module tb_strike_controller;
  import billiard_pkg::*;

  localparam int unsigned AW = DEF_ANGLE_W;
  localparam int unsigned PW = DEF_POWER_W;

  logic clk    = 1'b0;
  logic resetN = 1'b1;

  int checks       = 0;
  int failures     = 0;
  int strikes_seen = 0;

  typedef struct packed {
    logic [AW-1:0] angle;
    logic [PW-1:0] power;
  } shot_t;

  typedef struct {
    logic          left;
    logic          right;
    int            frames;
    logic [AW-1:0] angle;
  } aim_vec_t;

  shot_t    exp_q[$];
  aim_vec_t vecs[12];

  strike_controller_if #(.ANGLE_W(AW), .POWER_W(PW)) bus ();

  strike_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.startOfFrame = 1'b1;
      step();
      bus.startOfFrame = 1'b0;
      step();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strike"},   int'(bus.strike),       0);
    check({tag, "_angle"},    int'(bus.strike_angle), 0);
    check({tag, "_power"},    int'(bus.strike_power), 0);
    check({tag, "_charging"}, int'(bus.charging),     0);
    check({tag, "_aim"},      int'(bus.aim_visible),  0);
  endtask

  // Scoreboard: every strike pulse must match the oldest expected shot.
  always @(negedge clk) begin
    if (bus.strike) begin
      strikes_seen++;
      if (exp_q.size() == 0) begin
        check("strike_unexpected", 1, 0);
      end else begin
        shot_t e;
        e = exp_q.pop_front();
        check("sb_angle", int'(bus.strike_angle), int'(e.angle));
        check("sb_power", int'(bus.strike_power), int'(e.power));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3, AW'(31)};
    vecs[1]  = '{1'b1, 1'b0, 3, AW'(30)};
    vecs[2]  = '{1'b1, 1'b0, 3, AW'(29)};
    vecs[3]  = '{1'b1, 1'b1, 6, AW'(29)};
    vecs[4]  = '{1'b0, 1'b1, 2, AW'(29)};
    vecs[5]  = '{1'b0, 1'b1, 1, AW'(30)};
    vecs[6]  = '{1'b0, 1'b0, 5, AW'(30)};
    vecs[7]  = '{1'b0, 1'b1, 2, AW'(30)};
    vecs[8]  = '{1'b0, 1'b0, 1, AW'(30)};
    vecs[9]  = '{1'b0, 1'b1, 2, AW'(30)};
    vecs[10] = '{1'b0, 1'b1, 1, AW'(31)};
    vecs[11] = '{1'b0, 1'b1, 3, AW'(0)};

    bus.startOfFrame   = 1'b0;
    bus.game_state     = 1'b0;
    bus.no_moving_flag = 1'b0;
    bus.charge_key     = 1'b0;
    bus.left_key       = 1'b0;
    bus.right_key      = 1'b0;

    #2 resetN = 1'b0;
    step(2);
    check_all_zero("reset");
    resetN = 1'b1;
    step();
    check("wait_no_game_aim", int'(bus.aim_visible), 0);

    bus.game_state     = 1'b1;
    bus.no_moving_flag = 1'b1;
    step();
    check("enter_aim", int'(bus.aim_visible), 1);
    check("enter_aim_charging", int'(bus.charging), 0);

    // Aim stepping, wrap and both-key hold.
    for (int i = 0; i < 12; i++) begin
      bus.left_key  = vecs[i].left;
      bus.right_key = vecs[i].right;
      frames(vecs[i].frames);
      check($sformatf("aim_vec%0d", i), int'(bus.strike_angle), int'(vecs[i].angle));
    end
    bus.left_key  = 1'b0;
    bus.right_key = 1'b0;

    // Normal shot: 12 frames of charge -> power 3, angle frozen while charging.
    bus.charge_key = 1'b1;
    step();
    check("charge_enter", int'(bus.charging), 1);
    check("charge_enter_power", int'(bus.strike_power), 0);
    bus.left_key = 1'b1;
    frames(12);
    bus.left_key = 1'b0;
    check("charge12_power", int'(bus.strike_power), 3);
    check("charge_angle_frozen", int'(bus.strike_angle), 0);
    exp_q.push_back('{angle: AW'(0), power: PW'(3)});
    bus.charge_key = 1'b0;
    step();
    check("fire_strike", int'(bus.strike), 1);
    check("fire_power", int'(bus.strike_power), 3);
    check("fire_aim", int'(bus.aim_visible), 0);
    step();
    check("post_fire_strike", int'(bus.strike), 0);
    check("post_fire_power", int'(bus.strike_power), 0);

    // Weak shot that never moves: cooldown expires after 30 frames.
    frames(29);
    check("cooldown29_aim", int'(bus.aim_visible), 0);
    frames(1);
    check("cooldown30_aim", int'(bus.aim_visible), 1);

    // Saturation, then motion gating in WAIT.
    bus.charge_key = 1'b1;
    step();
    frames(100);
    check("sat_power", int'(bus.strike_power), 15);
    exp_q.push_back('{angle: AW'(0), power: PW'(15)});
    bus.charge_key = 1'b0;
    step();
    check("sat_strike", int'(bus.strike), 1);
    check("sat_strike_power", int'(bus.strike_power), 15);
    step();
    bus.no_moving_flag = 1'b0;
    step();
    bus.charge_key = 1'b1;
    step(4);
    check("moving_wait_aim", int'(bus.aim_visible), 0);
    check("moving_wait_charging", int'(bus.charging), 0);
    bus.no_moving_flag = 1'b1;
    step(2);
    check("held_key_no_autofire", int'(bus.aim_visible), 0);
    bus.charge_key = 1'b0;
    step();
    check("release_to_aim", int'(bus.aim_visible), 1);

    // Zero-power release: back to aim, no strike.
    bus.charge_key = 1'b1;
    step();
    frames(3);
    check("zero_power", int'(bus.strike_power), 0);
    bus.charge_key = 1'b0;
    step();
    check("zero_strike", int'(bus.strike), 0);
    check("zero_aim", int'(bus.aim_visible), 1);
    check("zero_charging", int'(bus.charging), 0);
    step(3);

    // game_state drop mid-charge: power cleared, angle kept.
    bus.right_key = 1'b1;
    frames(3);
    bus.right_key = 1'b0;
    check("angle_one", int'(bus.strike_angle), 1);
    bus.charge_key = 1'b1;
    step();
    frames(28);
    check("charge28_power", int'(bus.strike_power), 7);
    bus.game_state = 1'b0;
    step();
    check("gamedrop_power", int'(bus.strike_power), 0);
    check("gamedrop_charging", int'(bus.charging), 0);
    check("gamedrop_aim", int'(bus.aim_visible), 0);
    check("gamedrop_angle", int'(bus.strike_angle), 1);
    bus.game_state = 1'b1;
    bus.charge_key = 1'b0;
    step();
    check("regain_aim", int'(bus.aim_visible), 1);

    // Asynchronous reset in the middle of a charge.
    bus.charge_key = 1'b1;
    step();
    frames(28);
    check("rst_charge_power", int'(bus.strike_power), 7);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    resetN = 1'b1;
    step(3);
    check("after_rst_held_key", int'(bus.aim_visible), 0);
    bus.charge_key = 1'b0;
    step();
    check("after_rst_aim", int'(bus.aim_visible), 1);
    check("after_rst_angle", int'(bus.strike_angle), 0);

    step(5);
    check("sb_pending", exp_q.size(), 0);
    check("strike_count", strikes_seen, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
